// File: rtl/serial_add_ctrl_if.sv
// Request/response bundle between a requesting unit and serial_add_ctrl.
//   start  : request strobe (requester -> adder)
//   op_a   : operand A, WIDTH bits
//   op_b   : operand B, WIDTH bits
//   cin    : carry-in
//   busy   : high while the serial addition runs (adder -> requester)
//   done   : one-cycle pulse, result valid from this cycle
//   sum    : registered WIDTH-bit result, held until the next accepted start
//   cout   : registered final carry, held with sum
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Requesting unit side
    modport master (
        output start, op_a, op_b, cin,
        input  busy, done, sum, cout
    );

    // Adder controller side
    modport slave (
        input  start, op_a, op_b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. Time-shares one external full-adder cell to
// compute {cout, sum} = op_a + op_b + cin, LSB first, one bit per cycle.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : request/response bundle (serial_add_ctrl_if.slave)
//   fa_a  : full-adder input a (operand A bit), 0 outside RUN
//   fa_b  : full-adder input b (operand B bit), 0 outside RUN
//   fa_c  : full-adder input c (carry feedback), 0 outside RUN
//   fa_x  : full-adder sum output
//   fa_y  : full-adder carry-out
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_add_ctrl_if.slave      bus,
    output logic                  fa_a,
    output logic                  fa_b,
    output logic                  fa_c,
    input  logic                  fa_x,
    input  logic                  fa_y
);

    localparam int unsigned CNT_W_RAW = $clog2(WIDTH + 1);
    localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [WIDTH-1:0]  sh_a;
    logic [WIDTH-1:0]  sh_b;
    logic              carry;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  res;
    logic [WIDTH-1:0]  res_shift;

    logic              load;
    logic              step;
    logic              last;

    // Result assembly: new sum bit enters at the MSB, earlier bits move down.
    if (WIDTH == 1) begin : g_res_w1
        assign res_shift = fa_x;
    end else begin : g_res_wn
        assign res_shift = {fa_x, res[WIDTH-1:1]};
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and full-adder drive
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        fa_a       = 1'b0;
        fa_b       = 1'b0;
        fa_c       = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                step = 1'b1;
                fa_a = sh_a[0];
                fa_b = sh_b[0];
                fa_c = carry;
                if (cnt == LAST_CNT) begin
                    last       = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand shifters, carry feedback, bit counter and partial result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_a  <= '0;
            sh_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            res   <= '0;
        end else if (load) begin
            sh_a  <= bus.op_a;
            sh_b  <= bus.op_b;
            carry <= bus.cin;
            cnt   <= '0;
            res   <= '0;
        end else if (step) begin
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            carry <= fa_y;
            cnt   <= cnt + CNT_W'(1);
            res   <= res_shift;
        end
    end

    // Held result, captured on the final bit of a run
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.sum  <= '0;
            bus.cout <= 1'b0;
        end else if (last) begin
            bus.sum  <= res_shift;
            bus.cout <= fa_y;
        end
    end

    // Status flags registered from the next state so they track state exactly
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.busy <= (state_next == S_RUN);
            bus.done <= (state_next == S_DONE);
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed testbench for serial_add_ctrl with WIDTH=8 and a behavioural
// full-adder cell on the fa_* ports.
module tb_serial_add_ctrl;

    localparam int unsigned WIDTH = 8;

    logic clk;
    logic rst_n;
    logic fa_a, fa_b, fa_c, fa_x, fa_y;

    int tests_run;
    int tests_failed;
    int cyc;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus_if ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave),
        .fa_a  (fa_a),
        .fa_b  (fa_b),
        .fa_c  (fa_c),
        .fa_x  (fa_x),
        .fa_y  (fa_y)
    );

    // Full-adder cell: x = sum, y = carry-out
    assign fa_x = fa_a ^ fa_b ^ fa_c;
    assign fa_y = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One operation from start; returns in the done cycle (posedge+1).
    // poke_run pulses start with other operands during the 3rd RUN cycle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input bit poke_run,
                          output logic [7:0] s, output logic co,
                          output int busy_n, output int done_at, output int accept_cyc);
        busy_n  = 0;
        done_at = 0;
        bus_if.start = 1'b1;
        bus_if.op_a  = a;
        bus_if.op_b  = b;
        bus_if.cin   = c;
        @(posedge clk); #1;
        accept_cyc   = cyc;
        bus_if.start = 1'b0;
        bus_if.op_a  = ~a;
        bus_if.op_b  = ~b;
        bus_if.cin   = ~c;
        for (int k = 1; k <= 40; k++) begin
            if (bus_if.busy && bus_if.done) begin
                tests_run++;
                tests_failed++;
                $display("FAIL busy_done_overlap: busy=1 done=1 at cycle %0d, required not both", k);
            end
            if (!bus_if.busy) begin
                tests_run++;
                if ({fa_a, fa_b, fa_c} !== 3'b000) begin
                    tests_failed++;
                    $display("FAIL fa_idle_zero: fa_abc=%b, required 000", {fa_a, fa_b, fa_c});
                end
            end
            if (bus_if.busy) busy_n++;
            if (bus_if.done) begin
                done_at = k;
                break;
            end
            bus_if.start = poke_run && (k == 3);
            if (poke_run && k == 3) begin
                bus_if.op_a = 8'hAA;
                bus_if.op_b = 8'h55;
            end
            @(posedge clk); #1;
        end
        bus_if.start = 1'b0;
        s  = bus_if.sum;
        co = bus_if.cout;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus_if.start = 1'b0;
        bus_if.op_a  = '0;
        bus_if.op_b  = '0;
        bus_if.cin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({bus_if.busy, bus_if.done, bus_if.cout} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: busy/done/cout=%b, required 000",
                     {bus_if.busy, bus_if.done, bus_if.cout});
        end
        tests_run++;
        if (bus_if.sum !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_sum: sum=%h, required 00", bus_if.sum);
        end
        tests_run++;
        if ({fa_a, fa_b, fa_c} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_fa: fa_abc=%b, required 000", {fa_a, fa_b, fa_c});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic c, input logic [7:0] exp_s, input logic exp_co);
        logic [7:0] s;
        logic       co;
        int         busy_n, done_at, acc;
        run_op(a, b, c, 1'b0, s, co, busy_n, done_at, acc);
        tests_run++;
        if (done_at != 9) begin
            tests_failed++;
            $display("FAIL %s_latency: done seen at cycle %0d, required 9", name, done_at);
        end
        tests_run++;
        if (busy_n != 8) begin
            tests_failed++;
            $display("FAIL %s_busy_cycles: busy cycles=%0d, required 8", name, busy_n);
        end
        tests_run++;
        if (s !== exp_s || co !== exp_co) begin
            tests_failed++;
            $display("FAIL %s_result: cout,sum=%b,%h required %b,%h", name, co, s, exp_co, exp_s);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_handshake();
        logic [7:0] s;
        logic       co;
        int         busy_n, done_at, acc;
        int         extra_done, extra_busy;
        run_op(8'h12, 8'h34, 1'b0, 1'b1, s, co, busy_n, done_at, acc);
        tests_run++;
        if (s !== 8'h46 || co !== 1'b0 || done_at != 9) begin
            tests_failed++;
            $display("FAIL hs_result: cout,sum=%b,%h at cycle %0d required 0,46 at 9", co, s, done_at);
        end
        // Start pulse during the DONE cycle must be ignored
        bus_if.start = 1'b1;
        bus_if.op_a  = 8'hAA;
        bus_if.op_b  = 8'h55;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        tests_run++;
        if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL hs_done_start_ignored: busy=%b done=%b, required 0 0", bus_if.busy, bus_if.done);
        end
        extra_done = 0;
        extra_busy = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus_if.done) extra_done++;
            if (bus_if.busy) extra_busy++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (extra_done != 0 || extra_busy != 0) begin
            tests_failed++;
            $display("FAIL hs_idle: extra done=%0d busy=%0d, required 0 0", extra_done, extra_busy);
        end
        tests_run++;
        if (bus_if.sum !== 8'h46 || bus_if.cout !== 1'b0) begin
            tests_failed++;
            $display("FAIL hs_hold: cout,sum=%b,%h required 0,46", bus_if.cout, bus_if.sum);
        end
    endtask

    task automatic test_reset_midrun();
        logic [7:0] s;
        logic       co;
        int         busy_n, done_at, acc, stray_done;
        bus_if.start = 1'b1;
        bus_if.op_a  = 8'h80;
        bus_if.op_b  = 8'h80;
        bus_if.cin   = 1'b0;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        // Now in the 4th RUN cycle
        tests_run++;
        if (bus_if.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mr_busy_before: busy=%b, required 1", bus_if.busy);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tests_run++;
        if ({bus_if.busy, bus_if.done, bus_if.cout} !== 3'b000 || bus_if.sum !== 8'h00) begin
            tests_failed++;
            $display("FAIL mr_after_reset: busy,done,cout=%b sum=%h required 000 00",
                     {bus_if.busy, bus_if.done, bus_if.cout}, bus_if.sum);
        end
        stray_done = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus_if.done || bus_if.busy) stray_done++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (stray_done != 0) begin
            tests_failed++;
            $display("FAIL mr_no_done: active cycles after reset=%0d, required 0", stray_done);
        end
        run_op(8'h80, 8'h80, 1'b0, 1'b0, s, co, busy_n, done_at, acc);
        tests_run++;
        if (s !== 8'h00 || co !== 1'b1 || done_at != 9) begin
            tests_failed++;
            $display("FAIL mr_rerun: cout,sum=%b,%h at cycle %0d required 1,00 at 9", co, s, done_at);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b, s;
        logic       c, co;
        logic [8:0] exp;
        int         busy_n, done_at, acc, prev_acc;
        prev_acc = 0;
        for (int i = 0; i < 500; i++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            c   = 1'($urandom);
            exp = 9'(a) + 9'(b) + 9'(c);
            run_op(a, b, c, 1'b0, s, co, busy_n, done_at, acc);
            tests_run++;
            if ({co, s} !== exp || done_at != 9) begin
                tests_failed++;
                $display("FAIL b2b_result[%0d]: %h+%h+%b gave %h at cycle %0d, required %h at 9",
                         i, a, b, c, {co, s}, done_at, exp);
            end
            if (i > 0) begin
                tests_run++;
                if (acc - prev_acc != WIDTH + 2) begin
                    tests_failed++;
                    $display("FAIL b2b_spacing[%0d]: spacing=%0d, required %0d", i, acc - prev_acc, WIDTH + 2);
                end
            end
            prev_acc = acc;
            // Start is raised in the cycle after done
            @(posedge clk); #1;
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_add("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        test_add("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        test_add("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        test_add("add_00_00_c", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
        test_handshake();
        test_reset_midrun();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller that time-shares one full-adder cell (rep3: inputs a,b,c; outputs x=sum, y=carry-out) to add two WIDTH-bit operands plus carry-in, LSB first.
- The cell sits outside this block and connects through the fa_* ports.
- Handles the start/busy/done handshake, operand shifting, carry feedback and result assembly.
- Sits between a requesting unit and the full-adder datapath; trades area for WIDTH-cycle latency.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1 to 32.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  request strobe; sampled only in IDLE.
- op_a  input  WIDTH  operand A, captured on the accepted start.
- op_b  input  WIDTH  operand B, captured on the accepted start.
- cin  input  1  carry-in, captured on the accepted start.
- fa_a  output  1  to full-adder a.
- fa_b  output  1  to full-adder b.
- fa_c  output  1  to full-adder c.
- fa_x  input  1  full-adder sum.
- fa_y  input  1  full-adder carry-out.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; the result is valid from this cycle.
- sum  output  WIDTH  registered result; held until the next accepted start.
- cout  output  1  registered final carry; held with sum.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; shift registers, carry register, bit counter, sum and cout all 0; busy=0, done=0.
  - Reset overrides every other event, including a run in progress: the operation is aborted, no done pulse is issued, and sum/cout are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge: load sh_a<=op_a, sh_b<=op_b, carry<=cin, cnt<=0, res<=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - Combinational outputs: fa_a=sh_a[0], fa_b=sh_b[0], fa_c=carry.
  - Each edge: sh_a and sh_b shift right, filling 0; res<={fa_x, res[WIDTH-1:1]}; carry<=fa_y; cnt<=cnt+1.
  - When cnt==WIDTH-1 at an edge: sum<={fa_x, res[WIDTH-1:1]}, cout<=fa_y; go to DONE.
  - start is ignored in RUN; operand inputs may change freely without effect.
- DONE:
  - done=1 for exactly one cycle, then unconditionally go to IDLE.
  - start is ignored in DONE.
- fa_a/fa_b/fa_c are driven 0 in IDLE and DONE.
- busy is 1 exactly in RUN; done and busy are never high together.
- Latency: with start accepted at edge E0, RUN occupies the cycles after edges E0..E(WIDTH-1), and done is high in the cycle after edge E(WIDTH). Maximum throughput is one operation per WIDTH+2 cycles.
- WIDTH=1: a single RUN cycle; res is unused beyond sum[0].
- Counter width: clog2(WIDTH+1) bits, minimum 1; it never wraps within a run.
- Arithmetic: {cout,sum} = op_a + op_b + cin, with a full WIDTH+1-bit result; overflow appears only in cout.
- The datapath is purely combinational, so there is no fa_* pipeline delay; the controller samples fa_x/fa_y in the same cycle it drives fa_a/fa_b/fa_c.

Test Plan:
- Bench setup: instantiate rep3 on fa_*; WIDTH=8.
  1. start with op_a=0x5A, op_b=0x3C, cin=0 → busy high 8 cycles, done pulse in the 9th cycle after start edge, sum=0x96, cout=0.
  2. op_a=0xFF, op_b=0x01, cin=0 → sum=0x00, cout=1.
  3. op_a=0xFF, op_b=0xFF, cin=1 → sum=0xFF, cout=1.
  4. Handshake and hold:
     - Run op_a=0x12, op_b=0x34, cin=0.
     - Pulse start with op_a=0xAA, op_b=0x55 during RUN and again during DONE.
     - Required: sum=0x46, cout=0; exactly one done; the block returns to IDLE; sum holds 0x46 for 20 idle cycles.
  5. Reset mid-run:
     - Start 0x80+0x80 and drive rst_n=0 at the 4th RUN cycle.
     - Required: next cycle state=IDLE, busy=0, sum=0x00, cout=0, no done pulse.
     - A subsequent start 0x80+0x80 gives sum=0x00, cout=1.
  6. Randomised: 500 back-to-back operations (start asserted the cycle after each done) with random op_a/op_b/cin.
     - Required: {cout,sum}==op_a+op_b+cin for every operation, fa_* all 0 whenever busy=0, and spacing of exactly WIDTH+2 cycles between accepted starts.
